// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
// The writeback request carries a destination index and the value to write.
package regfile_ctrl_pkg;

    localparam int DATA_W    = 64;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On contention it grants the requester
// that did not win the previous contended cycle.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    grant_t last_grant;
    logic   contended;

    assign contended = req_alu & req_mem;

    // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
        if (contended) begin
            gnt_alu = (last_grant == GRANT_MEM);
            gnt_mem = (last_grant == GRANT_ALU);
        end
    end

    // Uncontested grants leave the history alone, so fairness only tracks real conflicts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_MEM;
        end else if (contended) begin
            last_grant <= gnt_alu ? GRANT_ALU : GRANT_MEM;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller and busy-bit scoreboard for the 32x64 register file.
// Arbitrates ALU and load writebacks onto registered regfile write signals.
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    input  logic                 issue_valid,
    input  logic                 issue_writes,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    output logic                 issue_stall,
    output logic                 RegWrite,
    output logic [REG_IDX_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]    WriteData,
    output logic                 sb_err
);

    logic [NUM_REGS-1:0] busy;
    wb_req_t             sel_req;
    logic                accept;
    logic                issue_fire;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (alu_ready),
        .gnt_mem (mem_ready)
    );

    assign accept = alu_ready | mem_ready;

    always_comb begin
        sel_req.rd   = mem_reg;
        sel_req.data = mem_data;
        if (alu_ready) begin
            sel_req.rd   = alu_reg;
            sel_req.data = alu_data;
        end
    end

    // No bypass: a register stays busy through the cycle its write is on the port.
    assign issue_stall = issue_valid &
                         (busy[issue_rs1] | busy[issue_rs2] | (issue_writes & busy[issue_rd]));
    assign issue_fire  = issue_valid & ~issue_stall & issue_writes & (issue_rd != ZERO_REG);

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= accept & (sel_req.rd != ZERO_REG);
            if (accept) begin
                WriteRegister <= sel_req.rd;
                WriteData     <= sel_req.data;
            end
        end
    end

    // NOTE: the busy vector is plain flops, so it is reset along with the port; this drops in-flight tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            if (RegWrite) begin
                busy[WriteRegister] <= 1'b0;
                if (!busy[WriteRegister]) begin
                    sb_err <= 1'b1;
                end
            end
            // A WAW stall keeps this from ever targeting the register being retired.
            if (issue_fire) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed scenarios plus random traffic
// checked against a cycle-level model of grants, busy registers and retired writes.
module tb_regfile_wb_ctrl;
    import regfile_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 alu_valid, mem_valid, alu_ready, mem_ready;
    logic [REG_IDX_W-1:0] alu_reg, mem_reg;
    logic [DATA_W-1:0]    alu_data, mem_data;
    logic                 issue_valid, issue_writes, issue_stall;
    logic [REG_IDX_W-1:0] issue_rd, issue_rs1, issue_rs2;
    logic                 RegWrite, sb_err;
    logic [REG_IDX_W-1:0] WriteRegister;
    logic [DATA_W-1:0]    WriteData;

    regfile_wb_ctrl dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic                 busy_m [NUM_REGS];
    logic                 sb_m;
    grant_t               last_m;
    logic                 infl_v;
    logic [REG_IDX_W-1:0] infl_r;
    wb_req_t              exp_q [$];
    logic                 m_acc_alu, m_acc_mem, d_ar, d_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < NUM_REGS; r++) busy_m[r] = 1'b0;
        sb_m   = 1'b0;
        last_m = GRANT_MEM;
        infl_v = 1'b0;
        infl_r = '0;
        exp_q.delete();
    endfunction

    // Monitor: every write the DUT presents must be the oldest one the model expects.
    initial begin
        wb_req_t e;
        forever begin
            @(negedge clk);
            if (!reset && RegWrite) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got write reg %0d data %0h, expected none", WriteRegister, WriteData);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_reg", WriteRegister, e.rd);
                    check("wb_data", WriteData, e.data);
                end
            end
        end
    end

    // One clock cycle: check combinational outputs, then advance the model across the edge.
    task automatic step();
        logic exp_ar, exp_mr, exp_stall, contended;
        wb_req_t w;
        #1;
        contended = alu_valid && mem_valid;
        exp_ar    = alu_valid && (!mem_valid || last_m == GRANT_MEM);
        exp_mr    = mem_valid && !exp_ar;
        exp_stall = issue_valid && (busy_m[issue_rs1] || busy_m[issue_rs2] ||
                                    (issue_writes && busy_m[issue_rd]));
        d_ar    = alu_ready;
        d_stall = issue_stall;
        check("alu_ready", alu_ready, exp_ar);
        check("mem_ready", mem_ready, exp_mr);
        check("issue_stall", issue_stall, exp_stall);
        check("sb_err", sb_err, sb_m);
        @(posedge clk);
        if (infl_v) begin
            if (!busy_m[infl_r]) sb_m = 1'b1;
            busy_m[infl_r] = 1'b0;
        end
        if (issue_valid && !exp_stall && issue_writes && issue_rd != ZERO_REG)
            busy_m[issue_rd] = 1'b1;
        infl_v = 1'b0;
        if (exp_ar || exp_mr) begin
            w.rd   = exp_ar ? alu_reg : mem_reg;
            w.data = exp_ar ? alu_data : mem_data;
            if (w.rd != ZERO_REG) begin
                infl_v = 1'b1;
                infl_r = w.rd;
                exp_q.push_back(w);
            end
        end
        if (contended) last_m = exp_ar ? GRANT_ALU : GRANT_MEM;
        m_acc_alu = exp_ar;
        m_acc_mem = exp_mr;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_wreg", WriteRegister, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_sb_err", sb_err, 0);
        alu_valid = 0; mem_valid = 0; issue_valid = 0; issue_writes = 0;
        alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0;
        issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Random writebacks target registers the model believes busy, or the zero register.
    function automatic logic [REG_IDX_W-1:0] pick_wb_reg(output logic ok);
        logic [REG_IDX_W-1:0] cands [$];
        logic [REG_IDX_W-1:0] rr;
        ok = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
            ok = 1'b1;
            return ZERO_REG;
        end
        for (int r = 0; r < NUM_REGS - 1; r++) begin
            rr = REG_IDX_W'(r);
            if (busy_m[r] && !(alu_valid && alu_reg == rr) && !(mem_valid && mem_reg == rr) &&
                !(infl_v && infl_r == rr))
                cands.push_back(rr);
        end
        if (cands.size() == 0) return '0;
        ok = 1'b1;
        return cands[$urandom_range(0, cands.size() - 1)];
    endfunction

    function automatic logic [REG_IDX_W-1:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return ZERO_REG;
        return REG_IDX_W'($urandom_range(0, 11));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ai, mi;
        logic ok;
        logic [REG_IDX_W-1:0] r;
        reset = 1'b0;
        alu_valid = 0; mem_valid = 0; issue_valid = 0; issue_writes = 0;
        #2;
        do_reset();

        // Single ALU write: accepted at once, visible one cycle, then RegWrite drops
        alu_valid = 1; alu_reg = 5; alu_data = 64'hDEAD;
        step();
        check("t1_ready", d_ar, 1);
        alu_valid = 0;
        check("t1_regwrite", RegWrite, 1);
        check("t1_wreg", WriteRegister, 5);
        check("t1_wdata", WriteData, 64'hDEAD);
        step();
        check("t1_regwrite_off", RegWrite, 0);
        check("t1_wreg_hold", WriteRegister, 5);

        // Contention: grants alternate, losers hold their request
        ai = 0; mi = 0;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1; alu_reg = REG_IDX_W'(1 + ai); alu_data = 64'hA000 + 64'(ai);
            mem_valid = 1; mem_reg = REG_IDX_W'(9 + mi); mem_data = 64'hB000 + 64'(mi);
            step();
            check("t2_grant_alu", d_ar, (k % 2 == 0));
            if (m_acc_alu) ai++;
            if (m_acc_mem) mi++;
        end
        alu_valid = 0; mem_valid = 0;
        step(); step();

        // RAW / WAW stalls and release the cycle after the write lands
        do_reset();
        issue_valid = 1; issue_writes = 1; issue_rd = 7; issue_rs1 = 0; issue_rs2 = 0;
        step();
        check("t3_issue_ok", d_stall, 0);
        issue_writes = 0; issue_rs1 = 7;
        step();
        check("t3_raw_stall", d_stall, 1);
        issue_writes = 1; issue_rd = 7; issue_rs1 = 0;
        step();
        check("t3_waw_stall", d_stall, 1);
        issue_rd = ZERO_REG;
        step();
        check("t3_zero_rd", d_stall, 0);
        issue_writes = 0; issue_rs1 = ZERO_REG; issue_rs2 = ZERO_REG;
        step();
        check("t3_zero_src", d_stall, 0);
        issue_rs1 = 7; issue_rs2 = 0;
        mem_valid = 1; mem_reg = 7; mem_data = 64'h7777;
        step();
        check("t3_stall_on_accept", d_stall, 1);
        mem_valid = 0;
        check("t3_wr7_valid", RegWrite, 1);
        check("t3_wr7_reg", WriteRegister, 7);
        step();
        check("t3_stall_during_write", d_stall, 1);
        step();
        check("t3_stall_release", d_stall, 0);
        issue_valid = 0;

        // Zero-register writeback is swallowed; retire to idle register flags sb_err
        do_reset();
        mem_valid = 1; mem_reg = ZERO_REG; mem_data = 64'h1234;
        step();
        mem_valid = 0;
        check("t5_no_regwrite", RegWrite, 0);
        step();
        check("t5_sb_clear", sb_err, 0);
        alu_valid = 1; alu_reg = 3; alu_data = 64'h3333;
        step();
        alu_valid = 0;
        step();
        check("t5_sb_set", sb_err, 1);
        step(); step();
        check("t5_sb_sticky", sb_err, 1);

        // Reset in the middle of a write clears outputs and scoreboard
        do_reset();
        issue_valid = 1; issue_writes = 1; issue_rd = 2;
        step();
        issue_rd = 8;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_reg = 2; alu_data = 64'h2222;
        step();
        alu_valid = 0;
        check("t6_midwrite", RegWrite, 1);
        do_reset();
        issue_valid = 1; issue_writes = 0; issue_rs1 = 2; issue_rs2 = 8;
        step();
        check("t6_post_reset_stall", d_stall, 0);
        issue_valid = 0;
        step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid && $urandom_range(0, 1) == 1) begin
                r = pick_wb_reg(ok);
                if (ok) begin
                    alu_valid = 1; alu_reg = r; alu_data = {$urandom, $urandom};
                end
            end
            if (!mem_valid && $urandom_range(0, 1) == 1) begin
                r = pick_wb_reg(ok);
                if (ok) begin
                    mem_valid = 1; mem_reg = r; mem_data = {$urandom, $urandom};
                end
            end
            issue_valid  = ($urandom_range(0, 1) == 1);
            issue_writes = ($urandom_range(0, 2) != 0);
            issue_rd     = rand_reg();
            issue_rs1    = rand_reg();
            issue_rs2    = rand_reg();
            step();
            if (m_acc_alu) alu_valid = 0;
            if (m_acc_mem) mem_valid = 0;
        end
        issue_valid = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (m_acc_alu) alu_valid = 0;
            if (m_acc_mem) mem_valid = 0;
        end
        @(negedge clk);
        #1;
        check("wb_queue_drained", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
